// File: rtl/user_credits_wr.sv
// Credit-gated write request issuer: holds one upstream request until enough
// buffered data beats and an outstanding slot are available, then forwards it.
module user_credits_wr #(
   parameter int DATA_BITS     = 512,
   parameter int LEN_BITS      = 28,
   parameter int REQ_BITS      = 96,
   parameter int N_OUTSTANDING = 8,
   localparam int BEAT_LOG     = $clog2(DATA_BITS / 8),
   localparam int BLEN_BITS    = LEN_BITS - BEAT_LOG + 1,
   localparam int CNT_BITS     = BLEN_BITS + 1,
   localparam int OUT_BITS     = $clog2(N_OUTSTANDING + 1)
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                s_req_valid,
   output logic                s_req_ready,
   input  logic [LEN_BITS-1:0] s_req_len,
   input  logic [REQ_BITS-1:0] s_req_data,
   output logic                m_req_valid,
   input  logic                m_req_ready,
   output logic [LEN_BITS-1:0] m_req_len,
   output logic [REQ_BITS-1:0] m_req_data,
   input  logic                wxfer,
   input  logic                wdone,
   output logic [CNT_BITS-1:0] data_cnt,
   output logic [OUT_BITS-1:0] outst_cnt,
   output logic                ovf
);

   localparam int SUM_BITS = CNT_BITS + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_BITS-1:0]   len_q, len_d;
   logic [REQ_BITS-1:0]   data_q, data_d;
   logic [BLEN_BITS-1:0]  blen_q, blen_d;
   logic [CNT_BITS-1:0]   data_cnt_q, data_cnt_d;
   logic [OUT_BITS-1:0]   outst_cnt_q, outst_cnt_d;
   logic                  ovf_q, ovf_d;

   logic                  accept_s;
   logic                  claim_s;
   logic                  credit_ok_s;
   logic [LEN_BITS-1:0]   len_m1_s;
   logic [BLEN_BITS-1:0]  blen_s;
   logic [SUM_BITS-1:0]   sum_s;

   // Handshake decode and credit check, all from registered state
   always_comb begin
      accept_s    = s_req_valid && (state_q == ST_IDLE);
      claim_s     = m_req_ready && (state_q == ST_ISSUE);
      credit_ok_s = ({1'b0, data_cnt_q} >= SUM_BITS'(blen_q)) &&
                    (outst_cnt_q < OUT_BITS'(N_OUTSTANDING));
      len_m1_s    = s_req_len - LEN_BITS'(1);
      if (s_req_len == '0) begin
         blen_s = '0;
      end else begin
         blen_s = BLEN_BITS'(len_m1_s >> BEAT_LOG) + BLEN_BITS'(1);
      end
   end

   // State register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept_s)    state_d = ST_WAIT;  else state_d = ST_IDLE;
         ST_WAIT:  if (credit_ok_s) state_d = ST_ISSUE; else state_d = ST_WAIT;
         ST_ISSUE: if (claim_s)     state_d = ST_IDLE;  else state_d = ST_ISSUE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode; request fields are only presented while issuing
   always_comb begin
      s_req_ready = 1'b0;
      m_req_valid = 1'b0;
      m_req_len   = '0;
      m_req_data  = '0;
      case (state_q)
         ST_IDLE: s_req_ready = 1'b1;
         ST_ISSUE: begin
            m_req_valid = 1'b1;
            m_req_len   = len_q;
            m_req_data  = data_q;
         end
         default: begin
            s_req_ready = 1'b0;
            m_req_valid = 1'b0;
         end
      endcase
   end

   // Request latch and credit counters next values
   always_comb begin
      len_d  = len_q;
      data_d = data_q;
      blen_d = blen_q;
      if (accept_s) begin
         len_d  = s_req_len;
         data_d = s_req_data;
         blen_d = blen_s;
      end else begin
         blen_d = blen_q;
      end

      // Extra top bit catches a wxfer past all-ones; the claim cannot underflow
      sum_s = {1'b0, data_cnt_q} + SUM_BITS'(wxfer) -
              (claim_s ? SUM_BITS'(blen_q) : SUM_BITS'(0));
      if (sum_s[CNT_BITS]) begin
         data_cnt_d = '1;
      end else begin
         data_cnt_d = sum_s[CNT_BITS-1:0];
      end
      ovf_d = ovf_q | (wxfer & (&data_cnt_q));

      outst_cnt_d = outst_cnt_q;
      if (claim_s && !wdone) begin
         outst_cnt_d = outst_cnt_q + OUT_BITS'(1);
      end else if (wdone && !claim_s && (outst_cnt_q != '0)) begin
         outst_cnt_d = outst_cnt_q - OUT_BITS'(1);
      end else begin
         outst_cnt_d = outst_cnt_q;
      end
   end

   // Datapath and counter registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         len_q       <= '0;
         data_q      <= '0;
         blen_q      <= '0;
         data_cnt_q  <= '0;
         outst_cnt_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         len_q       <= len_d;
         data_q      <= data_d;
         blen_q      <= blen_d;
         data_cnt_q  <= data_cnt_d;
         outst_cnt_q <= outst_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign data_cnt  = data_cnt_q;
   assign outst_cnt = outst_cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_user_credits_wr.sv
// Directed bench for user_credits_wr: a scoreboard queue of expected downstream
// requests checked by a monitor, plus directed counter checks.
module tb_user_credits_wr;

   logic         clk = 1'b0;
   logic         areset;
   logic         s_req_valid, s_req_ready;
   logic [27:0]  s_req_len;
   logic [95:0]  s_req_data;
   logic         m_req_valid, m_req_ready;
   logic [27:0]  m_req_len;
   logic [95:0]  m_req_data;
   logic         wxfer, wdone;
   logic [23:0]  data_cnt;
   logic [3:0]   outst_cnt;
   logic         ovf;

   // Small instance (LEN_BITS=8) for the saturation check
   logic         o_reset, o_wxfer, o_s_ready, o_m_valid, o_ovf;
   logic [7:0]   o_m_len;
   logic [95:0]  o_m_data;
   logic [3:0]   o_data_cnt;
   logic [3:0]   o_outst_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [27:0] len;
      logic [95:0] data;
   } req_t;
   req_t exp_q[$];

   always #5 clk = ~clk;

   user_credits_wr dut (
      .aclk(clk), .areset(areset),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_len(s_req_len), .s_req_data(s_req_data),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_len(m_req_len), .m_req_data(m_req_data),
      .wxfer(wxfer), .wdone(wdone),
      .data_cnt(data_cnt), .outst_cnt(outst_cnt), .ovf(ovf)
   );

   user_credits_wr #(.LEN_BITS(8)) dut_ovf (
      .aclk(clk), .areset(o_reset),
      .s_req_valid(1'b0), .s_req_ready(o_s_ready),
      .s_req_len(8'd0), .s_req_data(96'd0),
      .m_req_valid(o_m_valid), .m_req_ready(1'b0),
      .m_req_len(o_m_len), .m_req_data(o_m_data),
      .wxfer(o_wxfer), .wdone(1'b0),
      .data_cnt(o_data_cnt), .outst_cnt(o_outst_cnt), .ovf(o_ovf)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one upstream request (block is expected idle) and record the expected issue
   task automatic send_req(input logic [27:0] len, input logic [95:0] data);
      req_t r;
      check("s_req_ready before send", s_req_ready, 1'b1);
      s_req_valid = 1'b1;
      s_req_len   = len;
      s_req_data  = data;
      r.len  = len;
      r.data = data;
      exp_q.push_back(r);
      tick();
      s_req_valid = 1'b0;
   endtask

   // Monitor: compare every downstream handshake against the scoreboard
   always @(negedge clk) begin
      if (!areset && m_req_valid && m_req_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected m_req: len %0h data %0h, expected no request", m_req_len, m_req_data);
         end else begin
            req_t e;
            e = exp_q.pop_front();
            check("m_req_len", m_req_len, e.len);
            check("m_req_data", m_req_data, e.data);
         end
      end
   end

   initial begin
      areset = 1'b1; o_reset = 1'b1;
      s_req_valid = 1'b0; s_req_len = '0; s_req_data = '0;
      m_req_ready = 1'b1; wxfer = 1'b0; wdone = 1'b0; o_wxfer = 1'b0;
      tick(2);
      areset = 1'b0; o_reset = 1'b0;
      check("reset s_req_ready", s_req_ready, 1'b1);
      check("reset m_req_valid", m_req_valid, 1'b0);
      check("reset data_cnt", data_cnt, 24'd0);
      check("reset outst_cnt", outst_cnt, 4'd0);
      check("reset ovf", ovf, 1'b0);

      // Basic issue: 256 bytes = 4 beats, data arrives after the request
      send_req(28'd256, 96'hA1A2_A3A4_A5A6_A7A8_A9AA_ABAC);
      wxfer = 1'b1;
      tick(4);
      wxfer = 1'b0;
      check("basic data_cnt=4", data_cnt, 24'd4);
      check("basic still waiting", m_req_valid, 1'b0);
      tick();
      check("basic m_req_valid", m_req_valid, 1'b1);
      tick();
      check("basic data_cnt after", data_cnt, 24'd0);
      check("basic outst_cnt after", outst_cnt, 4'd1);
      check("basic back to idle", s_req_ready, 1'b1);

      // Data buffered first: 10 beats, then 100 bytes = 2 beats
      wxfer = 1'b1;
      tick(10);
      wxfer = 1'b0;
      check("prebuf data_cnt=10", data_cnt, 24'd10);
      send_req(28'd100, 96'h1111_2222_3333_4444_5555_6666);
      check("prebuf valid 1 cycle", m_req_valid, 1'b0);
      tick();
      check("prebuf valid 2 cycles", m_req_valid, 1'b1);
      tick();
      check("prebuf data_cnt=8", data_cnt, 24'd8);
      check("prebuf outst_cnt=2", outst_cnt, 4'd2);

      // 320 bytes = 5 beats brings data_cnt to 3
      send_req(28'd320, 96'h0BAD_CAFE_0000_0000_0000_0005);
      tick(2);
      check("claim5 data_cnt=3", data_cnt, 24'd3);
      check("claim5 outst_cnt=3", outst_cnt, 4'd3);

      // Simultaneous wxfer, 3-beat claim and wdone
      m_req_ready = 1'b0;
      send_req(28'd192, 96'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0);
      tick();
      check("simul in issue", m_req_valid, 1'b1);
      m_req_ready = 1'b1; wxfer = 1'b1; wdone = 1'b1;
      tick();
      wxfer = 1'b0; wdone = 1'b0;
      check("simul data_cnt=1", data_cnt, 24'd1);
      check("simul outst_cnt=3", outst_cnt, 4'd3);

      // Drain completions; a wdone at zero is ignored
      wdone = 1'b1;
      tick(4);
      wdone = 1'b0;
      check("drain outst_cnt=0", outst_cnt, 4'd0);

      // Outstanding limit with zero-length requests
      for (int i = 0; i < 8; i++) begin
         send_req(28'd0, 96'(i + 16'h7700));
         tick(2);
      end
      check("limit outst_cnt=8", outst_cnt, 4'd8);
      check("zero-len keeps data_cnt", data_cnt, 24'd1);
      send_req(28'd0, 96'hDEAD_BEEF_0000_0000_0000_0009);
      tick(3);
      check("limit 9th held", m_req_valid, 1'b0);
      check("limit still 8", outst_cnt, 4'd8);
      wdone = 1'b1;
      tick();
      wdone = 1'b0;
      check("limit wdone outst=7", outst_cnt, 4'd7);
      tick();
      check("limit 9th issues", m_req_valid, 1'b1);
      tick();
      check("limit outst back to 8", outst_cnt, 4'd8);

      wdone = 1'b1;
      tick(8);
      wdone = 1'b0;
      check("drain2 outst_cnt=0", outst_cnt, 4'd0);

      // Backpressure in issue, then reset (with wxfer/wdone ignored)
      m_req_ready = 1'b0;
      send_req(28'd64, 96'hFEED_FACE_1234_5678_9ABC_DEF0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp m_req_valid", m_req_valid, 1'b1);
         check("bp m_req_len", m_req_len, 28'd64);
         check("bp m_req_data", m_req_data, 96'hFEED_FACE_1234_5678_9ABC_DEF0);
         tick();
      end
      areset = 1'b1; wxfer = 1'b1; wdone = 1'b1;
      tick();
      areset = 1'b0; wxfer = 1'b0; wdone = 1'b0;
      exp_q.delete();
      check("rst m_req_valid", m_req_valid, 1'b0);
      check("rst s_req_ready", s_req_ready, 1'b1);
      check("rst data_cnt", data_cnt, 24'd0);
      check("rst outst_cnt", outst_cnt, 4'd0);
      check("rst ovf", ovf, 1'b0);

      // Overflow on the 4-bit counter
      o_wxfer = 1'b1;
      tick(15);
      check("ovf cnt=15", o_data_cnt, 4'd15);
      check("ovf not yet", o_ovf, 1'b0);
      tick();
      o_wxfer = 1'b0;
      check("ovf saturate", o_data_cnt, 4'd15);
      check("ovf set", o_ovf, 1'b1);
      tick(3);
      check("ovf sticky", o_ovf, 1'b1);
      o_reset = 1'b1;
      tick();
      o_reset = 1'b0;
      check("ovf cleared", o_ovf, 1'b0);
      check("ovf cnt cleared", o_data_cnt, 4'd0);

      m_req_ready = 1'b1;
      tick(2);
      check("scoreboard empty", 96'(exp_q.size()), 96'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/user_credits_wr.md
USER_CREDITS_WR -- requirements
Module: user_credits_wr

Interface
REQ-001 Parameter DATA_BITS, default 512, shall set the data-beat width in bits; one beat is DATA_BITS/8 bytes, and BEAT_LOG = log2(DATA_BITS/8).
REQ-002 Parameter LEN_BITS, default 28, shall set the byte-length field width.
REQ-003 Parameter REQ_BITS, default 96, shall set the width of the opaque request payload.
REQ-004 Parameter N_OUTSTANDING, default 8, shall set the maximum number of issued, uncompleted writes.
REQ-005 Derived widths:
- BLEN_BITS = LEN_BITS - BEAT_LOG + 1.
- CNT_BITS = BLEN_BITS + 1.
REQ-006 Port list (name, direction, width, meaning):
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  reset; synchronous, active-high.
- s_req_valid  in  1  upstream write request valid.
- s_req_ready  out  1  upstream request accept.
- s_req_len  in  LEN_BITS  write length in bytes.
- s_req_data  in  REQ_BITS  opaque request payload.
- m_req_valid  out  1  downstream write request valid.
- m_req_ready  in  1  downstream accept.
- m_req_len  out  LEN_BITS  latched length.
- m_req_data  out  REQ_BITS  latched payload.
- wxfer  in  1  one write-data beat buffered upstream this cycle.
- wdone  in  1  one issued write completed this cycle.
- data_cnt  out  CNT_BITS  buffered, unclaimed beats.
- outst_cnt  out  $clog2(N_OUTSTANDING+1)  issued, uncompleted writes.
- ovf  out  1  sticky flag: data counter overflow.

Function
REQ-007 Beat count of a request: blen = 0 if len == 0, else ((len - 1) >> BEAT_LOG) + 1, computed at BLEN_BITS width.
REQ-008 The FSM shall have three states: ST_IDLE, ST_WAIT and ST_ISSUE.
REQ-009 In ST_IDLE, s_req_ready shall be 1; the only other output that may be 1 in ST_IDLE is ovf.
REQ-010 On s_req_valid && s_req_ready, the block shall:
- latch len, payload and blen;
- move to ST_WAIT.
REQ-011 ST_WAIT shall move to ST_ISSUE in the first cycle in which both data_cnt >= blen and outst_cnt < N_OUTSTANDING hold; evaluation uses registered counter values.
REQ-012 In ST_ISSUE:
- m_req_valid shall be 1, with m_req_len/m_req_data equal to the latched values;
- these outputs shall hold stable until m_req_ready;
- on the handshake the FSM shall return to ST_IDLE.
REQ-013 Request latency shall be 2 cycles minimum from s_req handshake to m_req_valid; the next s_req may be accepted the cycle after the m_req handshake.
REQ-014 data_cnt update each cycle: next = data_cnt + wxfer - (blen if m_req handshake else 0).
- The claim and wxfer in the same cycle shall both apply.
- The claim shall never underflow, as guaranteed by REQ-011.
REQ-015 A wxfer when data_cnt is all-ones shall:
- leave data_cnt unchanged, unless a claim occurs in the same cycle;
- set ovf, which remains 1 until reset.
REQ-016 outst_cnt update:
- +1 on m_req handshake without wdone;
- -1 on wdone without handshake;
- unchanged when both occur.
REQ-017 A wdone when outst_cnt == 0 shall be ignored, unless a handshake occurs in the same cycle, in which case REQ-016 applies.
REQ-018 A zero-length request (blen = 0) shall pass ST_WAIT without consuming data and still occupy one outstanding slot.
REQ-019 Counter outputs shall be driven directly from registers.
REQ-020 s_req_ready and m_req_valid shall be decoded from the registered state only, with no combinational path from inputs.

Reset
REQ-021 While areset is high at a rising edge, the block shall set:
- state to ST_IDLE;
- data_cnt, outst_cnt and ovf to 0;
- the latched len/payload/blen to 0.
REQ-022 Reset asserted mid-operation, including ST_ISSUE with m_req_valid high, shall take effect on that edge: m_req_valid = 0 and s_req_ready = 1 in the following cycle.
REQ-023 wxfer and wdone shall be ignored during reset cycles.

Verification
REQ-024 Basic issue (DATA_BITS=512):
- stimulus: s_req len=256, then 4 wxfer pulses, m_req_ready=1;
- response: m_req_valid rises the cycle after data_cnt reaches 4 (ST_WAIT to ST_ISSUE); data_cnt returns to 0 and outst_cnt becomes 1 after the handshake.
REQ-025 Data already buffered:
- stimulus: 10 wxfer pulses, then s_req len=100 (2 beats);
- response: m_req_valid 2 cycles after the s_req handshake; data_cnt=8 after issue.
REQ-026 Outstanding limit (N_OUTSTANDING=8):
- stimulus: 8 zero-length requests issued with no wdone, then a 9th request;
- response: the 9th request stays in ST_WAIT with outst_cnt=8; one wdone lets it issue, leaving outst_cnt=8.
REQ-027 Simultaneous events:
- stimulus: wxfer together with an m_req handshake claiming 3 beats from data_cnt=3, and wdone in the same cycle;
- response: data_cnt=1, outst_cnt unchanged.
REQ-028 Backpressure and reset:
- stimulus: hold m_req_ready=0 for 5 cycles in ST_ISSUE, then assert areset;
- response: m_req_len/m_req_data are stable during the 5 cycles; the next cycle shows m_req_valid=0, s_req_ready=1 and all counters 0.
REQ-029 Overflow (LEN_BITS=8):
- stimulus: with LEN_BITS=8 (CNT_BITS=4), drive 16 wxfer pulses;
- response: data_cnt saturates at 15 and ovf=1 stays high until areset.
